tag_lookup_issue: RTL and testbench

//  Front end of the DRAM cache controller. Accepts single-beat host AXI reads/writes, issues one tag+data line

---
 rtl/tag_lookup_issue.sv | 181 ++++++++++++++++++
 tb/tb_tag_lookup_issue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_issue.sv
// Front end of the DRAM cache controller: accepts one host read or write at a time, issues the
// line-slot read to the memory controller and pushes tag FIFO / write buffer / ROB entries in order.
module tag_lookup_issue #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int ID_WIDTH     = 4,
   parameter int INDEX_WIDTH  = 10,
   parameter int OFFSET_WIDTH = 6,
   parameter int TID_WIDTH    = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ID_WIDTH-1:0]             arid_i,
   input  logic [ADDR_WIDTH-1:0]           araddr_i,
   input  logic                            arvalid_i,
   output logic                            arready_o,
   input  logic [ID_WIDTH-1:0]             awid_i,
   input  logic [ADDR_WIDTH-1:0]           awaddr_i,
   input  logic                            awvalid_i,
   output logic                            awready_o,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   input  logic                            wvalid_i,
   output logic                            wready_o,
   output logic [ID_WIDTH-1:0]             bid_o,
   output logic [1:0]                      bresp_o,
   output logic                            bvalid_o,
   input  logic                            bready_i,
   output logic [ID_WIDTH-1:0]             mem_arid_o,
   output logic [ADDR_WIDTH-1:0]           mem_araddr_o,
   output logic                            mem_arvalid_o,
   input  logic                            mem_arready_i,
   input  logic                            tag_fifo_afull_i,
   output logic                            tag_fifo_wren_o,
   output logic [TID_WIDTH+ADDR_WIDTH:0]   tag_fifo_data_o,
   input  logic                            wbuffer_afull_i,
   output logic                            wbuffer_wren_o,
   output logic [DATA_WIDTH-1:0]           wbuffer_data_o,
   input  logic                            rob_alloc_afull_i,
   output logic                            rob_alloc_wren_o,
   output logic [TID_WIDTH+ID_WIDTH-1:0]   rob_alloc_data_o
);

   localparam int SLOT_WIDTH = INDEX_WIDTH + OFFSET_WIDTH;
   // Keeps index+offset, clears the tag field: the memory read targets the line slot.
   localparam logic [ADDR_WIDTH-1:0] SLOT_MASK =
      {{(ADDR_WIDTH-SLOT_WIDTH){1'b0}}, {SLOT_WIDTH{1'b1}}};
   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_WR_DATA  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_WR_RESP  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [TID_WIDTH-1:0]    tid_q, tid_d;
   logic                    last_grant_q, last_grant_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rd_ok_s, wr_ok_s, grant_rd_s, grant_wr_s;

   assign bresp_o = 2'b00;

   // Next-state and output decode; every output defaults to idle/zero.
   always_comb begin
      state_d          = state_q;
      tid_d            = tid_q;
      last_grant_d     = last_grant_q;
      id_d             = id_q;
      addr_d           = addr_q;
      rd_ok_s          = arvalid_i & ~tag_fifo_afull_i & ~rob_alloc_afull_i;
      wr_ok_s          = awvalid_i & ~tag_fifo_afull_i & ~wbuffer_afull_i;
      grant_rd_s       = 1'b0;
      grant_wr_s       = 1'b0;
      arready_o        = 1'b0;
      awready_o        = 1'b0;
      wready_o         = 1'b0;
      bvalid_o         = 1'b0;
      bid_o            = {ID_WIDTH{1'b0}};
      mem_arvalid_o    = 1'b0;
      mem_araddr_o     = {ADDR_WIDTH{1'b0}};
      mem_arid_o       = {ID_WIDTH{1'b0}};
      tag_fifo_wren_o  = 1'b0;
      tag_fifo_data_o  = {(TID_WIDTH+ADDR_WIDTH+1){1'b0}};
      wbuffer_wren_o   = 1'b0;
      wbuffer_data_o   = {DATA_WIDTH{1'b0}};
      rob_alloc_wren_o = 1'b0;
      rob_alloc_data_o = {(TID_WIDTH+ID_WIDTH){1'b0}};
      case (state_q)
         S_IDLE: begin
            // When both sides are eligible, the side not served last wins.
            grant_rd_s = rd_ok_s & (~wr_ok_s | (last_grant_q == GRANT_WR));
            grant_wr_s = wr_ok_s & (~rd_ok_s | (last_grant_q == GRANT_RD));
            arready_o  = grant_rd_s;
            awready_o  = grant_wr_s;
            if (grant_rd_s) begin
               id_d         = arid_i;
               addr_d       = araddr_i;
               last_grant_d = GRANT_RD;
               state_d      = S_RD_ISSUE;
            end else if (grant_wr_s) begin
               id_d         = awid_i;
               addr_d       = awaddr_i;
               last_grant_d = GRANT_WR;
               state_d      = S_WR_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_ISSUE: begin
            mem_arvalid_o = 1'b1;
            mem_araddr_o  = addr_q & SLOT_MASK;
            mem_arid_o    = ID_WIDTH'(tid_q);
            if (mem_arready_i) begin
               tag_fifo_wren_o  = 1'b1;
               tag_fifo_data_o  = {1'b0, tid_q, addr_q};
               rob_alloc_wren_o = 1'b1;
               rob_alloc_data_o = {tid_q, id_q};
               tid_d            = tid_q + 1'b1;
               state_d          = S_IDLE;
            end else begin
               state_d = S_RD_ISSUE;
            end
         end
         S_WR_DATA: begin
            wready_o = 1'b1;
            if (wvalid_i) begin
               wbuffer_wren_o = 1'b1;
               wbuffer_data_o = wdata_i;
               state_d        = S_WR_ISSUE;
            end else begin
               state_d = S_WR_DATA;
            end
         end
         S_WR_ISSUE: begin
            mem_arvalid_o = 1'b1;
            mem_araddr_o  = addr_q & SLOT_MASK;
            if (mem_arready_i) begin
               tag_fifo_wren_o = 1'b1;
               tag_fifo_data_o = {1'b1, {TID_WIDTH{1'b0}}, addr_q};
               state_d         = S_WR_RESP;
            end else begin
               state_d = S_WR_ISSUE;
            end
         end
         S_WR_RESP: begin
            bvalid_o = 1'b1;
            bid_o    = id_q;
            if (bready_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WR_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight transaction without side effects.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tid_q        <= {TID_WIDTH{1'b0}};
         last_grant_q <= GRANT_WR;
         id_q         <= {ID_WIDTH{1'b0}};
         addr_q       <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         tid_q        <= tid_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
      end
   end

endmodule

// File: tb/tb_tag_lookup_issue.sv
// Randomized scoreboard bench for tag_lookup_issue: a transaction-level model predicts grants and
// queues expected pushes; an independent monitor pops and compares whenever the DUT emits something.
module tb_tag_lookup_issue;

   localparam int AW     = 32;
   localparam int DW     = 64;
   localparam int IW     = 4;
   localparam int IXW    = 10;
   localparam int OFW    = 6;
   localparam int TW     = 3;
   localparam int TAGD_W = TW + AW + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [IW-1:0]     arid_i, awid_i, bid_o, mem_arid_o;
   logic [AW-1:0]     araddr_i, awaddr_i, mem_araddr_o;
   logic              arvalid_i, arready_o, awvalid_i, awready_o;
   logic [DW-1:0]     wdata_i, wbuffer_data_o;
   logic              wvalid_i, wready_o;
   logic [1:0]        bresp_o;
   logic              bvalid_o, bready_i, mem_arvalid_o, mem_arready_i;
   logic              tag_fifo_afull_i, tag_fifo_wren_o;
   logic [TAGD_W-1:0] tag_fifo_data_o;
   logic              wbuffer_afull_i, wbuffer_wren_o;
   logic              rob_alloc_afull_i, rob_alloc_wren_o;
   logic [TW+IW-1:0]  rob_alloc_data_o;

   tag_lookup_issue #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
      .INDEX_WIDTH(IXW), .OFFSET_WIDTH(OFW), .TID_WIDTH(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arvalid_o(mem_arvalid_o),
      .mem_arready_i(mem_arready_i),
      .tag_fifo_afull_i(tag_fifo_afull_i), .tag_fifo_wren_o(tag_fifo_wren_o),
      .tag_fifo_data_o(tag_fifo_data_o),
      .wbuffer_afull_i(wbuffer_afull_i), .wbuffer_wren_o(wbuffer_wren_o),
      .wbuffer_data_o(wbuffer_data_o),
      .rob_alloc_afull_i(rob_alloc_afull_i), .rob_alloc_wren_o(rob_alloc_wren_o),
      .rob_alloc_data_o(rob_alloc_data_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=missing required=present", name);
   endtask

   // Scoreboard queues
   logic [IW+AW-1:0]  exp_mem[$];
   logic [TAGD_W-1:0] exp_tag[$];
   logic [TW+IW-1:0]  exp_rob[$];
   logic [DW-1:0]     exp_wb[$];
   logic [IW-1:0]     exp_b[$];

   // Reference model state
   int m_tid;
   bit m_last_wr, m_busy, m_cur_wr;

   // Host-side pending requests and stimulus knobs (percent)
   bit            ar_pend, aw_pend, w_pend;
   logic [IW-1:0] ar_id, aw_id;
   logic [AW-1:0] ar_addr, aw_addr;
   logic [DW-1:0] aw_data, w_data;
   int pct_ar, pct_aw, pct_wv, pct_taf, pct_waf, pct_raf, pct_mrdy, pct_brdy;

   function automatic bit chance(input int pct);
      return (int'($urandom_range(99)) < pct);
   endfunction

   function automatic logic [AW-1:0] slot_of(input logic [AW-1:0] a);
      return AW'(longint'(a) % (longint'(1) << (IXW + OFW)));
   endfunction

   task automatic model_reset();
      m_tid = 0; m_last_wr = 1'b1; m_busy = 1'b0; m_cur_wr = 1'b0;
      ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
   endtask

   task automatic set_knobs(input int ar, input int aw, input int wv, input int af,
                            input int mrdy, input int brdy);
      pct_ar = ar; pct_aw = aw; pct_wv = wv;
      pct_taf = af; pct_waf = af; pct_raf = af;
      pct_mrdy = mrdy; pct_brdy = brdy;
   endtask

   // One bus cycle: drive at negedge, predict grants and queue expectations 1 time unit later.
   task automatic cycle();
      bit rd_ok, wr_ok, g_rd, g_wr;
      @(negedge clk);
      if (!ar_pend && chance(pct_ar)) begin
         ar_pend = 1'b1; ar_id = IW'($urandom); ar_addr = $urandom;
      end
      if (!aw_pend && chance(pct_aw)) begin
         aw_pend = 1'b1; aw_id = IW'($urandom); aw_addr = $urandom; aw_data = {$urandom, $urandom};
      end
      arvalid_i = ar_pend; arid_i = ar_id; araddr_i = ar_addr;
      awvalid_i = aw_pend; awid_i = aw_id; awaddr_i = aw_addr;
      wvalid_i  = w_pend && chance(pct_wv);
      wdata_i   = wvalid_i ? w_data : {$urandom, $urandom};
      tag_fifo_afull_i  = chance(pct_taf);
      wbuffer_afull_i   = chance(pct_waf);
      rob_alloc_afull_i = chance(pct_raf);
      mem_arready_i     = chance(pct_mrdy);
      bready_i          = chance(pct_brdy);
      #1;
      rd_ok = ar_pend && !tag_fifo_afull_i && !rob_alloc_afull_i;
      wr_ok = aw_pend && !tag_fifo_afull_i && !wbuffer_afull_i;
      g_rd  = !m_busy && rd_ok && (!wr_ok || m_last_wr);
      g_wr  = !m_busy && wr_ok && (!rd_ok || !m_last_wr);
      check("arready", arready_o, g_rd);
      check("awready", awready_o, g_wr);
      check("wready", wready_o, m_busy && m_cur_wr && w_pend);
      if (m_busy && !m_cur_wr && mem_arvalid_o && mem_arready_i) m_busy = 1'b0;
      if (m_busy && m_cur_wr && bvalid_o && bready_i) m_busy = 1'b0;
      if (wvalid_i && wready_o) w_pend = 1'b0;
      if (g_rd) begin
         exp_mem.push_back({IW'(m_tid), slot_of(ar_addr)});
         exp_tag.push_back({1'b0, TW'(m_tid), ar_addr});
         exp_rob.push_back({TW'(m_tid), ar_id});
         m_tid = (m_tid + 1) % (1 << TW);
         m_last_wr = 1'b0; m_busy = 1'b1; m_cur_wr = 1'b0; ar_pend = 1'b0;
      end else if (g_wr) begin
         exp_mem.push_back({IW'(0), slot_of(aw_addr)});
         exp_tag.push_back({1'b1, TW'(0), aw_addr});
         exp_wb.push_back(aw_data);
         exp_b.push_back(aw_id);
         w_data = aw_data;
         m_last_wr = 1'b1; m_busy = 1'b1; m_cur_wr = 1'b1; aw_pend = 1'b0; w_pend = 1'b1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Monitor: pops expectations whenever the DUT presents a handshake or push.
   logic          prev_v;
   logic [AW-1:0] prev_a;
   logic [IW-1:0] prev_id;
   int            wb_seen, tag_wr_seen;
   logic          mem_hs;
   initial begin prev_v = 1'b0; wb_seen = 0; tag_wr_seen = 0; end

   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         mem_hs = mem_arvalid_o && mem_arready_i;
         if (prev_v) begin
            check("mem_arvalid_hold", mem_arvalid_o, 1'b1);
            check("mem_araddr_hold", mem_araddr_o, prev_a);
            check("mem_arid_hold", mem_arid_o, prev_id);
         end
         prev_v = mem_arvalid_o && !mem_arready_i;
         prev_a = mem_araddr_o; prev_id = mem_arid_o;
         check("tag_push_with_mem_ar", tag_fifo_wren_o, mem_hs);
         check("rob_push_with_read_tag", rob_alloc_wren_o,
               tag_fifo_wren_o && !tag_fifo_data_o[TAGD_W-1]);
         if (mem_hs) begin
            if (exp_mem.size() == 0) fail_now("mem_ar_unexpected");
            else check("mem_ar", {mem_arid_o, mem_araddr_o}, exp_mem.pop_front());
         end
         if (wbuffer_wren_o) begin
            wb_seen++;
            if (exp_wb.size() == 0) fail_now("wbuffer_unexpected");
            else check("wbuffer_data", wbuffer_data_o, exp_wb.pop_front());
         end
         if (tag_fifo_wren_o) begin
            if (tag_fifo_data_o[TAGD_W-1]) begin
               tag_wr_seen++;
               check("wbuffer_before_tag", wb_seen >= tag_wr_seen, 1'b1);
            end
            if (exp_tag.size() == 0) fail_now("tag_unexpected");
            else check("tag_data", tag_fifo_data_o, exp_tag.pop_front());
         end
         if (rob_alloc_wren_o) begin
            if (exp_rob.size() == 0) fail_now("rob_unexpected");
            else check("rob_data", rob_alloc_data_o, exp_rob.pop_front());
         end
         if (bvalid_o && bready_i) begin
            check("bresp", bresp_o, 2'b00);
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else check("bid", bid_o, exp_b.pop_front());
         end
      end else begin
         prev_v = 1'b0;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_arready"}, arready_o, 1'b0);
      check({tag, "_awready"}, awready_o, 1'b0);
      check({tag, "_wready"}, wready_o, 1'b0);
      check({tag, "_bvalid"}, bvalid_o, 1'b0);
      check({tag, "_bid"}, bid_o, '0);
      check({tag, "_mem_arvalid"}, mem_arvalid_o, 1'b0);
      check({tag, "_mem_ar"}, {mem_arid_o, mem_araddr_o}, '0);
      check({tag, "_tag_push"}, {tag_fifo_wren_o, tag_fifo_data_o}, '0);
      check({tag, "_wb_push"}, {wbuffer_wren_o, wbuffer_data_o}, '0);
      check({tag, "_rob_push"}, {rob_alloc_wren_o, rob_alloc_data_o}, '0);
   endtask

   task automatic drive_quiet();
      arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
      arid_i = '0; araddr_i = '0; awid_i = '0; awaddr_i = '0; wdata_i = '0;
      mem_arready_i = 1'b0; tag_fifo_afull_i = 1'b0; wbuffer_afull_i = 1'b0;
      rob_alloc_afull_i = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      drive_quiet();
      model_reset();
      set_knobs(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed read: tag field cleared on memory side, tid 0, rob {0,3}
      set_knobs(0, 0, 100, 0, 100, 100);
      ar_pend = 1'b1; ar_id = 4'd3; ar_addr = 32'h0001_2340;
      run(4);
      // Directed write
      aw_pend = 1'b1; aw_id = 4'd5; aw_addr = 32'h0000_0040; aw_data = 64'hA5A5_A5A5_A5A5_A5A5;
      run(8);
      // Simultaneous requests alternate
      for (int k = 0; k < 3; k++) begin
         ar_pend = 1'b1; ar_id = IW'($urandom); ar_addr = $urandom;
         aw_pend = 1'b1; aw_id = IW'($urandom); aw_addr = $urandom; aw_data = {$urandom, $urandom};
         run(10);
      end
      // Tag FIFO almost full blocks acceptance
      pct_taf = 100;
      ar_pend = 1'b1; ar_id = 4'd9; ar_addr = $urandom;
      run(5);
      pct_taf = 0;
      run(4);
      // Memory controller stalls the issue
      pct_mrdy = 0;
      ar_pend = 1'b1; ar_id = 4'd1; ar_addr = $urandom;
      run(7);
      pct_mrdy = 100;
      run(3);
      // TID wraparound
      for (int k = 0; k < (1 << TW) + 1; k++) begin
         ar_pend = 1'b1; ar_id = IW'(k); ar_addr = $urandom;
         run(3);
      end
      // Random traffic with backpressure
      set_knobs(40, 40, 60, 15, 60, 60);
      run(2000);
      // Drain
      set_knobs(0, 0, 100, 0, 100, 100);
      run(30);
      check("queues_drained",
            exp_mem.size() + exp_tag.size() + exp_rob.size() + exp_wb.size() + exp_b.size(), 0);
      check("host_requests_drained", {ar_pend, aw_pend, w_pend}, 3'b000);

      // Reset while the write response is waiting
      pct_brdy = 0;
      aw_pend = 1'b1; aw_id = 4'd12; aw_addr = $urandom; aw_data = {$urandom, $urandom};
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cycle();
         seen = bvalid_o;
      end
      if (!seen) fail_now("wait_bvalid_timeout");
      @(negedge clk);
      rst_n = 1'b0;
      drive_quiet();
      @(negedge clk);
      #1;
      check_idle_outputs("midreset");
      check("b_pending_at_reset", exp_b.size(), 1);
      exp_b.delete();
      check("pushes_done_at_reset", exp_mem.size() + exp_tag.size() + exp_wb.size(), 0);
      model_reset();
      rst_n = 1'b1;
      // After reset: immediate acceptance and tid restarts at 0
      ar_pend = 1'b1; ar_id = 4'd7; ar_addr = $urandom;
      run(4);
      check("post_reset_drained", exp_mem.size() + exp_tag.size() + exp_rob.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
